maze_walker: RTL and testbench

//  Initiator side of the maze-memory rd/wr/loc/dIn/dOut interface. On start, runs a depth-first

---
 rtl/maze_pkg.sv | 48 ++++
 rtl/dir_stack.sv | 55 +++++
 rtl/maze_walker.sv | 190 +++++++++++++++++++
 tb/tb_maze_walker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
//   Shared definitions for maze-memory clients: the move-direction encoding,
//   the default coordinate width, the walker FSM state type and a step()
//   helper that turns a direction into a (dx, dy) unit move.
//   dx/dy are 2-bit two's complement values in {-1, 0, +1}.
// -----------------------------------------------------------------------------
package maze_pkg;

  localparam int CW = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,  // y-1
    DIR_RIGHT = 2'd1,  // x+1
    DIR_LEFT  = 2'd2,  // x-1
    DIR_DOWN  = 2'd3   // y+1
  } dir_e;

  typedef struct packed {
    logic [1:0] dx;
    logic [1:0] dy;
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MARK,
    ST_CHECK,
    ST_READ,
    ST_WAIT,
    ST_POP,
    ST_DONE,
    ST_FAIL
  } walk_state_e;

  function automatic step_t step(input dir_e d);
    step_t s;
    s = '0;
    case (d)
      DIR_UP:    s.dy = 2'b11;
      DIR_RIGHT: s.dx = 2'b01;
      DIR_LEFT:  s.dx = 2'b11;
      DIR_DOWN:  s.dy = 2'b01;
      default:   s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dir_stack.sv
// -----------------------------------------------------------------------------
// dir_stack
//   DEPTH x 2-bit LIFO holding the directions of the moves on the current path.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (empties the stack)
//     clear           synchronous empty, same effect as rst
//     push, push_dir  push one direction (never asserted together with pop)
//     pop             discard the top entry
//     top_dir         current top entry, valid when count != 0
//     count           number of valid entries
//     rd_idx, rd_dir  asynchronous indexed read, index 0 = oldest entry
// -----------------------------------------------------------------------------
module dir_stack #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [1:0]       push_dir,
  output logic [1:0]       top_dir,
  output logic [CNT_W-1:0] count,
  input  logic [AW-1:0]    rd_idx,
  output logic [1:0]       rd_dir
);

  logic [1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (push) begin
      count <= count + 1'b1;
    end else if (pop) begin
      count <= count - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; count alone decides which entries
  // are valid, so clearing the contents would buy nothing.
  always_ff @(posedge clk) begin
    if (push && !rst && !clear) begin
      mem[count[AW-1:0]] <= push_dir;
    end
  end

  assign top_dir = mem[AW'(count - 1'b1)];
  assign rd_dir  = mem[rd_idx];

endmodule

// File: rtl/maze_walker.sv
// -----------------------------------------------------------------------------
// maze_walker
//   Depth-first search over a 2^CW x 2^CW maze held in an external 1-bit
//   memory. Each visited cell is marked by writing 1 to it; neighbours are
//   probed in the order up, right, left, down. The moves of the current path
//   live in a direction stack that outside logic can read by index.
//   Ports:
//     clk, rst           clock, synchronous active-high reset
//     start              one-cycle pulse, honoured only when not busy
//     loc, rd, wr, dIn   memory request ({y,x}, read strobe, write strobe, data)
//     dOut               memory read data, valid the cycle after rd
//     busy, done, fail   search running / goal reached / no path
//     path_len           number of moves on the path
//     path_idx, path_dir indexed path read, combinational
// -----------------------------------------------------------------------------
module maze_walker #(
  parameter int CW      = 4,
  parameter int DEPTH   = 256,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [2*CW-1:0] loc,
  output logic          rd,
  output logic          wr,
  output logic          dIn,
  input  logic          dOut,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [8:0]    path_len,
  input  logic [7:0]    path_idx,
  output logic [1:0]    path_dir
);

  import maze_pkg::*;

  localparam int STK_AW  = $clog2(DEPTH);
  localparam int STK_CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] SX  = CW'(START_X);
  localparam logic [CW-1:0] SY  = CW'(START_Y);
  localparam logic [CW-1:0] GX  = CW'(GOAL_X);
  localparam logic [CW-1:0] GY  = CW'(GOAL_Y);
  localparam logic [CW-1:0] MAX = {CW{1'b1}};

  // Sign-extend a 2-bit unit delta to coordinate width.
  function automatic logic [CW-1:0] ext(input logic [1:0] d);
    return {{(CW-1){d[1]}}, d[0]};
  endfunction

  walk_state_e       state;
  logic [CW-1:0]     cur_x, cur_y;
  logic [2:0]        try_dir;      // 0..3 = direction to probe, 4 = exhausted
  logic [CW-1:0]     nx, ny;       // neighbour in try_dir
  logic [CW-1:0]     bx, by;       // cell we came from (undo of top move)
  logic              off_grid;
  logic              at_goal;
  step_t             try_step, back_step;

  logic              stk_push, stk_pop, stk_clear;
  logic [1:0]        top_dir;
  logic [STK_CW-1:0] stk_count;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    off_grid  = 1'b0;
    try_step  = step(dir_e'(try_dir[1:0]));
    back_step = step(dir_e'(top_dir));
    nx        = cur_x + ext(try_step.dx);
    ny        = cur_y + ext(try_step.dy);
    bx        = cur_x - ext(back_step.dx);
    by        = cur_y - ext(back_step.dy);
    // Boundary test happens before any step is taken, so nx/ny never wrap.
    case (dir_e'(try_dir[1:0]))
      DIR_UP:    off_grid = (cur_y == '0);
      DIR_RIGHT: off_grid = (cur_x == MAX);
      DIR_LEFT:  off_grid = (cur_x == '0);
      DIR_DOWN:  off_grid = (cur_y == MAX);
      default:   off_grid = 1'b0;
    endcase
  end

  assign at_goal   = (cur_x == GX) && (cur_y == GY);
  assign stk_push  = (state == ST_WAIT) && !dOut;
  assign stk_pop   = (state == ST_POP) && (stk_count != '0);
  assign stk_clear = start && (state == ST_IDLE || state == ST_DONE || state == ST_FAIL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rd      <= 1'b0;
      wr      <= 1'b0;
      dIn     <= 1'b0;
      loc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
      cur_x   <= SX;
      cur_y   <= SY;
      try_dir <= '0;
    end else begin
      // Strobes are single-cycle; the branches below raise them for the
      // state being entered, while loc simply holds between requests.
      rd  <= 1'b0;
      wr  <= 1'b0;
      dIn <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            done    <= 1'b0;
            fail    <= 1'b0;
            busy    <= 1'b1;
            cur_x   <= SX;
            cur_y   <= SY;
            try_dir <= '0;
            wr      <= 1'b1;
            dIn     <= 1'b1;
            loc     <= {SY, SX};
            state   <= ST_MARK;
          end
        end
        ST_MARK: state <= ST_CHECK;
        ST_CHECK: begin
          if (at_goal) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (try_dir == 3'd4) begin
            state <= ST_POP;
          end else if (off_grid) begin
            try_dir <= try_dir + 3'd1;
          end else begin
            rd    <= 1'b1;
            loc   <= {ny, nx};
            state <= ST_READ;
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          if (dOut) begin
            try_dir <= try_dir + 3'd1;
            state   <= ST_CHECK;
          end else begin
            cur_x   <= nx;
            cur_y   <= ny;
            try_dir <= '0;
            wr      <= 1'b1;
            dIn     <= 1'b1;
            loc     <= {ny, nx};
            state   <= ST_MARK;
          end
        end
        ST_POP: begin
          if (stk_count == '0) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FAIL;
          end else begin
            cur_x   <= bx;
            cur_y   <= by;
            try_dir <= {1'b0, top_dir} + 3'd1;
            state   <= ST_CHECK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dir_stack #(.DEPTH(DEPTH)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (stk_clear),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dir (try_dir[1:0]),
    .top_dir  (top_dir),
    .count    (stk_count),
    .rd_idx   (STK_AW'(path_idx)),
    .rd_dir   (path_dir)
  );

  assign path_len = 9'(stk_count);

endmodule

// File: tb/tb_maze_walker.sv
// -----------------------------------------------------------------------------
// tb_maze_walker
//   Drives maze_walker against a behavioural maze memory. Each run pushes the
//   reference-model result into a queue; a monitor pops it when the walker
//   finishes and compares flags, path, busy duration and memory marks.
// -----------------------------------------------------------------------------
module tb_maze_walker;

  typedef struct {
    bit done;
    int len;
    int cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start, rd, wr, dIn, dOut, busy, done, fail;
  logic [7:0] loc, path_idx;
  logic [8:0] path_len;
  logic [1:0] path_dir;

  bit   load;
  bit   map_img [256];
  bit   mem     [256];
  bit   exp_mem [256];
  int   exp_path[$];
  exp_t exp_q[$];
  int   mon_count = 0;
  int   errors = 0;
  int   checks = 0;

  int DX [4] = '{0, 1, -1, 0};
  int DY [4] = '{-1, 0, 0, 1};

  always #5 clk = ~clk;

  maze_walker dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .loc      (loc),
    .rd       (rd),
    .wr       (wr),
    .dIn      (dIn),
    .dOut     (dOut),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .path_len (path_len),
    .path_idx (path_idx),
    .path_dir (path_dir)
  );

  // Maze memory: data is valid only the cycle after a read, noise otherwise.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= map_img[i];
    end else if (wr) begin
      mem[loc] <= 1'b1;
    end
    dOut <= rd ? mem[loc] : 1'($urandom);
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference DFS on cell coordinates: probe up/right/left/down, mark every
  // entered cell, backtrack when all four probes are used up.
  task automatic model_run(output exp_t e);
    bit mm [256];
    int stk[$];
    int cx, cy, td, nx, ny, d;
    mm = map_img;
    cx = 0; cy = 0; td = 0;
    e.cycles = 1;                 // mark of the start cell
    mm[0] = 1'b1;
    forever begin
      e.cycles++;                 // one decision cycle
      if (cx == 15 && cy == 15) begin e.done = 1'b1; break; end
      if (td == 4) begin
        e.cycles++;               // backtrack cycle
        if (stk.size() == 0) begin e.done = 1'b0; break; end
        d  = stk.pop_back();
        cx = cx - DX[d];
        cy = cy - DY[d];
        td = d + 1;
        continue;
      end
      nx = cx + DX[td];
      ny = cy + DY[td];
      if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin td++; continue; end
      e.cycles += 2;              // read request + data return
      if (mm[ny*16 + nx]) begin
        td++;
      end else begin
        stk.push_back(td);
        cx = nx; cy = ny; td = 0;
        mm[ny*16 + nx] = 1'b1;
        e.cycles++;
      end
    end
    e.len    = stk.size();
    exp_path = stk;
    exp_mem  = mm;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_map(input bit extra_start);
    exp_t e;
    int   target;
    pulse_load();
    model_run(e);
    exp_q.push_back(e);
    target = mon_count + 1;
    pulse_start();
    if (extra_start) begin
      repeat (17) @(negedge clk);
      pulse_start();              // must be ignored while busy
    end
    for (int c = 0; c < 20000 && mon_count != target; c++) @(negedge clk);
    check("run_complete", mon_count, target);
    @(negedge clk);
  endtask

  task automatic map_fill(input bit v);
    for (int i = 0; i < 256; i++) map_img[i] = v;
  endtask

  // Monitor: protocol every cycle, scoreboard compare at end of each search.
  initial begin
    bit   pb, prd, pwr;
    int   bcnt, bad, memerr, x, y;
    exp_t e;
    path_idx = '0;
    pb = 1'b0; prd = 1'b0; pwr = 1'b0; bcnt = 0;
    forever begin
      @(negedge clk);
      check("rd_and_wr", rd & wr, 0);
      check("din_with_wr", wr & ~dIn, 0);
      check("rd_single_cycle", prd & rd, 0);
      check("wr_single_cycle", pwr & wr, 0);
      check("loc_known", $isunknown(loc), 0);
      prd = rd;
      pwr = wr;
      if (busy) bcnt = pb ? bcnt + 1 : 1;
      if (pb && !busy && (done || fail)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done", done, e.done);
          check("fail", fail, !e.done);
          check("path_len", path_len, e.len);
          check("busy_cycles", bcnt, e.cycles);
          bad = 0; x = 0; y = 0;
          for (int i = 0; i < int'(path_len) && i < 256; i++) begin
            path_idx = 8'(i);
            #1;
            if (i >= e.len || path_dir !== 2'(exp_path[i])) bad++;
            x += DX[path_dir];
            y += DY[path_dir];
          end
          check("path_dirs", bad, 0);
          if (e.done) begin
            check("end_x", x, 15);
            check("end_y", y, 15);
          end
          memerr = 0;
          for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) memerr++;
          check("mem_marks", memerr, 0);
        end
        mon_count++;
      end
      pb = busy;
    end
  end

  // Stimulus
  initial begin
    int nrd;
    rst = 1'b1; start = 1'b0; load = 1'b0;
    map_fill(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fail", fail, 0);
    check("reset_rd", rd, 0);
    check("reset_wr", wr, 0);
    check("reset_loc", loc, 0);
    check("reset_path_len", path_len, 0);

    // All-open grid
    map_fill(1'b0);
    run_map(1'b0);

    // Column x=1 walled: unreachable goal, everything reachable gets marked
    map_fill(1'b0);
    for (int y = 0; y < 16; y++) map_img[y*16 + 1] = 1'b1;
    run_map(1'b0);

    // Corridor: row 0, then column 15
    map_fill(1'b1);
    for (int i = 0; i < 16; i++) begin
      map_img[i] = 1'b0;
      map_img[i*16 + 15] = 1'b0;
    end
    run_map(1'b0);

    // Dead-end branch to the right of the start forces backtracking
    map_fill(1'b1);
    for (int x = 0; x < 4; x++) map_img[x] = 1'b0;
    for (int y = 0; y < 16; y++) map_img[y*16] = 1'b0;
    for (int x = 0; x < 16; x++) map_img[15*16 + x] = 1'b0;
    run_map(1'b0);

    // Random maps, one with a start pulse issued mid-search
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) map_img[i] = ($urandom_range(99) < 30);
      run_map(r == 1);
    end

    // Reset while waiting on read data
    map_fill(1'b0);
    pulse_load();
    pulse_start();
    nrd = 0;
    for (int c = 0; c < 2000 && nrd < 10; c++) begin
      @(negedge clk);
      if (rd) nrd++;
    end
    check("rd_seen_before_reset", nrd, 10);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 0);
    check("midreset_rd", rd, 0);
    check("midreset_wr", wr, 0);
    check("midreset_path_len", path_len, 0);
    check("midreset_done", done, 0);
    check("midreset_fail", fail, 0);

    // Reload and rerun the open grid
    map_fill(1'b0);
    run_map(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
